// File: rtl/mac_rx_pkg.sv
// Shared types, geometry and helpers for the MAC RX slot scheduler.
// The buffer geometry is fixed here so that the descriptor struct and
// every module that imports it agree on field widths.
package mac_rx_pkg;

  localparam int NUM_SLOTS   = 4;
  localparam int SLOT_ADDR_W = 9;
  localparam int DAT_W       = 32;
  localparam int BEN_W       = 2;
  localparam int SLOT_W      = $clog2(NUM_SLOTS);
  localparam int LEN_W       = SLOT_ADDR_W + 1;
  localparam int ADDR_W      = SLOT_W + SLOT_ADDR_W;
  localparam int SLOT_WORDS  = 1 << SLOT_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [LEN_W-1:0]  len;
    logic [BEN_W-1:0]  lastben;
    logic              trunc;
  } pkt_desc_t;

  // Byte-enable code to data mask: code n keeps the n+1 low-order bytes.
  function automatic logic [DAT_W-1:0] ben_to_mask(input logic [BEN_W-1:0] ben);
    logic [DAT_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < DAT_W / 8; b++) begin
      if (b <= int'(ben)) begin
        mask[b*8 +: 8] = 8'hFF;
      end else begin
        mask[b*8 +: 8] = 8'h00;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/mac_rx_desc_fifo.sv
// In-order queue of committed packet descriptors, first-word-fall-through.
// The head entry and its valid flag are registered; the next head is
// computed ahead of the edge so a pop and push in the same cycle on a
// single-entry queue hands the new descriptor straight to the head.
module mac_rx_desc_fifo
  import mac_rx_pkg::*;
#(
  parameter int DEPTH = NUM_SLOTS
) (
  input  logic      mac_clk_i,
  input  logic      ARESETN,
  input  logic      push,
  input  pkt_desc_t push_desc,
  input  logic      pop,
  output logic      head_valid,
  output pkt_desc_t head_desc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pkt_desc_t        mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             do_pop_s;
  logic             valid_r;
  pkt_desc_t        head_r;
  pkt_desc_t        head_s;

  // Next occupancy, read pointer and head entry.
  always_comb begin
    do_pop_s = pop & valid_r;
    rd_ptr_s = do_pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    case ({push, do_pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
    if (count_s == CNT_W'(0)) begin
      head_s = '0;
    end else if (push && (wr_ptr_r == rd_ptr_s)) begin
      head_s = push_desc;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Descriptor storage; entries are only read after being written.
  always_ff @(posedge mac_clk_i) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_desc;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      wr_ptr_r <= push ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      valid_r  <= (count_s != CNT_W'(0));
      head_r   <= head_s;
    end
  end

  assign head_valid = valid_r;
  assign head_desc  = head_r;

endmodule

// File: rtl/mac_rx_slot_sched.sv
// MAC RX stream scheduler into a slotted packet buffer.
// One packet per slot; packets arriving with no free slot are dropped.
// A slot leaves the free map when the packet starts and returns when the
// consumer releases the descriptor. If a packet's first beat lacks sop,
// the slot is kept (held) and reused by the following packet.
module mac_rx_slot_sched
  import mac_rx_pkg::*;
(
  input  logic                 mac_clk_i,
  input  logic                 ARESETN,
  input  logic [DAT_W-1:0]     mac_rxd_i,
  input  logic [BEN_W-1:0]     mac_ben_i,
  input  logic                 mac_rxda_i,
  input  logic                 mac_rxsop_i,
  input  logic                 mac_rxeop_i,
  input  logic                 mac_rxdv_i,
  output logic                 mac_rxrqrd_o,
  output logic                 wr_en_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [DAT_W-1:0]     wr_data_o,
  output logic                 pkt_valid_o,
  output logic [SLOT_W-1:0]    pkt_slot_o,
  output logic [LEN_W-1:0]     pkt_len_o,
  output logic [BEN_W-1:0]     pkt_lastben_o,
  output logic                 pkt_trunc_o,
  input  logic                 pkt_release_i,
  output logic [31:0]          pkt_count_o,
  output logic [15:0]          drop_count_o
);

  rx_state_e             state_r;
  logic                  rqrd_r;
  logic                  held_r;
  logic                  trunc_r;
  logic [SLOT_W-1:0]     slot_r;
  logic [LEN_W-1:0]      ptr_r;
  logic [NUM_SLOTS-1:0]  free_r;
  logic [NUM_SLOTS-1:0]  free_s;
  logic                  wr_en_r;
  logic [ADDR_W-1:0]     wr_addr_r;
  logic [DAT_W-1:0]      wr_data_r;
  logic [31:0]           pkt_count_r;
  logic [15:0]           drop_count_r;

  logic                  alloc_found_s;
  logic [SLOT_W-1:0]     alloc_idx_s;
  logic                  alloc_take_s;
  logic                  in_write_s;
  logic                  first_bad_s;
  logic                  wr_beat_s;
  logic                  room_s;
  logic                  write_s;
  logic                  commit_s;
  logic                  drop_s;
  logic                  trunc_s;
  logic                  release_s;
  logic [LEN_W-1:0]      eff_ptr_s;
  logic [LEN_W-1:0]      len_s;
  logic [DAT_W-1:0]      data_mask_s;
  pkt_desc_t             push_desc_s;
  pkt_desc_t             head_desc_s;
  logic                  head_valid_s;

  // Lowest-index free slot (priority encoder over the free map).
  always_comb begin
    alloc_found_s = 1'b0;
    alloc_idx_s   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      alloc_found_s = alloc_found_s | free_r[i];
      alloc_idx_s   = free_r[i] ? SLOT_W'(i) : alloc_idx_s;
    end
  end

  // Per-beat decode: pointer restart on sop, slot-size truncation, commit/drop.
  always_comb begin
    in_write_s   = (state_r == ST_WRITE) && mac_rxdv_i;
    first_bad_s  = in_write_s && (ptr_r == LEN_W'(0)) && !mac_rxsop_i;
    wr_beat_s    = in_write_s && !first_bad_s;
    eff_ptr_s    = mac_rxsop_i ? LEN_W'(0) : ptr_r;
    room_s       = ~eff_ptr_s[SLOT_ADDR_W];
    write_s      = wr_beat_s && room_s;
    commit_s     = wr_beat_s && mac_rxeop_i;
    drop_s       = ((state_r == ST_DROP) && mac_rxdv_i && mac_rxeop_i) ||
                   (first_bad_s && mac_rxeop_i);
    trunc_s      = (mac_rxsop_i ? 1'b0 : trunc_r) | ~room_s;
    len_s        = room_s ? (eff_ptr_s + LEN_W'(1)) : eff_ptr_s;
    data_mask_s  = mac_rxeop_i ? ben_to_mask(mac_ben_i) : '1;
    release_s    = pkt_release_i && head_valid_s;
    alloc_take_s = (state_r == ST_IDLE) && mac_rxda_i && !held_r && alloc_found_s;
    push_desc_s.slot    = slot_r;
    push_desc_s.len     = len_s;
    push_desc_s.lastben = mac_ben_i;
    push_desc_s.trunc   = trunc_s;
  end

  // Free map update: allocation clears a bit, release sets the head's bit.
  always_comb begin
    free_s                    = free_r;
    free_s[alloc_idx_s]       = free_s[alloc_idx_s] & ~alloc_take_s;
    free_s[head_desc_s.slot]  = free_s[head_desc_s.slot] | release_s;
  end

  // Slot free map register.
  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      free_r <= '1;
    end else begin
      free_r <= free_s;
    end
  end

  // RX FSM with registered read request, write port and counters.
  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      state_r      <= ST_IDLE;
      rqrd_r       <= 1'b0;
      held_r       <= 1'b0;
      trunc_r      <= 1'b0;
      slot_r       <= '0;
      ptr_r        <= '0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      pkt_count_r  <= 32'd0;
      drop_count_r <= 16'd0;
    end else begin
      wr_en_r <= write_s;
      if (write_s) begin
        wr_addr_r <= {slot_r, eff_ptr_s[SLOT_ADDR_W-1:0]};
        wr_data_r <= mac_rxd_i & data_mask_s;
      end
      if (commit_s) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
      case (state_r)
        ST_IDLE: begin
          rqrd_r <= mac_rxda_i;
          if (mac_rxda_i) begin
            if (held_r || alloc_found_s) begin
              slot_r  <= held_r ? slot_r : alloc_idx_s;
              held_r  <= 1'b1;
              ptr_r   <= '0;
              trunc_r <= 1'b0;
              state_r <= ST_WRITE;
            end else begin
              state_r <= ST_DROP;
            end
          end
        end
        ST_WRITE: begin
          rqrd_r <= mac_rxda_i;
          if (mac_rxdv_i) begin
            if (first_bad_s) begin
              // Stray continuation: discard it but keep the slot for later.
              if (mac_rxeop_i) begin
                rqrd_r  <= 1'b0;
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_DROP;
              end
            end else begin
              ptr_r   <= len_s;
              trunc_r <= trunc_s;
              if (mac_rxeop_i) begin
                rqrd_r  <= 1'b0;
                held_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
            end
          end
        end
        ST_DROP: begin
          rqrd_r <= mac_rxda_i;
          if (mac_rxdv_i && mac_rxeop_i) begin
            rqrd_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          rqrd_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  mac_rx_desc_fifo #(
    .DEPTH (NUM_SLOTS)
  ) u_desc_fifo (
    .mac_clk_i  (mac_clk_i),
    .ARESETN    (ARESETN),
    .push       (commit_s),
    .push_desc  (push_desc_s),
    .pop        (release_s),
    .head_valid (head_valid_s),
    .head_desc  (head_desc_s)
  );

  assign mac_rxrqrd_o  = rqrd_r;
  assign wr_en_o       = wr_en_r;
  assign wr_addr_o     = wr_addr_r;
  assign wr_data_o     = wr_data_r;
  assign pkt_valid_o   = head_valid_s;
  assign pkt_slot_o    = head_desc_s.slot;
  assign pkt_len_o     = head_desc_s.len;
  assign pkt_lastben_o = head_desc_s.lastben;
  assign pkt_trunc_o   = head_desc_s.trunc;
  assign pkt_count_o   = pkt_count_r;
  assign drop_count_o  = drop_count_r;

endmodule
